// File: rtl/window_pkg.sv
// Shared types and default geometry for the window scheduler
// and the window generator that consumes its fire events.
package window_pkg;

   // Scheduler FSM states.
   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_WAIT = 2'd1,
      ST_PEND = 2'd2
   } sched_state_t;

   localparam int DEF_WINDOW_SIZE = 32;
   localparam int DEF_STRIDE      = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), clr, inc, count[W-1:0].
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/window_sched.sv
// Sliding-window scheduler: tracks buffer fill and stride,
// offers each due window to a consumer via valid/ready.
// Ports: clk, rst (sync, active-high), en, in_valid,
//   fire_ready -> fire_valid, fire_idx, filled,
//   drop_cnt, overflow.
// Optional: WINDOW_SCHED_STATS_EN enables drop_cnt/overflow;
//   when undefined both outputs are tied to 0.
module window_sched
   import window_pkg::*;
#(
   parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
   parameter int STRIDE      = DEF_STRIDE,
   parameter int IDX_W       = 16,
   parameter int DROP_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   input  logic              fire_ready,
   output logic              fire_valid,
   output logic [IDX_W-1:0]  fire_idx,
   output logic              filled,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              overflow
);

   localparam int FW = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
   localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   localparam logic [FW-1:0] FILL_LAST   = FW'(WINDOW_SIZE - 1);
   localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE - 1);

   sched_state_t state_q;
   sched_state_t state_d;

   logic [FW-1:0]    fill_cnt_q;
   logic [FW-1:0]    fill_cnt_d;
   logic [SW-1:0]    stride_cnt_q;
   logic [SW-1:0]    stride_cnt_d;
   logic             filled_q;
   logic             filled_d;
   logic [IDX_W-1:0] fire_idx_q;
   logic [IDX_W-1:0] fire_idx_d;
   // Index the next due window will carry; fire_idx holds
   // the index of the pending (or most recent) window.
   logic [IDX_W-1:0] next_idx_q;
   logic [IDX_W-1:0] next_idx_d;

   logic due;
   logic take;

   always_comb begin
      state_d      = state_q;
      fill_cnt_d   = fill_cnt_q;
      stride_cnt_d = stride_cnt_q;
      filled_d     = filled_q;
      fire_idx_d   = fire_idx_q;
      next_idx_d   = next_idx_q;
      due          = 1'b0;

      // Sample accounting runs regardless of en so that the
      // window alignment survives a disabled period.
      if (in_valid) begin
         if (!filled_q) begin
            fill_cnt_d = fill_cnt_q + 1'b1;
            if (fill_cnt_q == FILL_LAST) begin
               filled_d = 1'b1;
               due      = 1'b1;
            end
         end else if (stride_cnt_q == STRIDE_LAST) begin
            stride_cnt_d = '0;
            due          = 1'b1;
         end else begin
            stride_cnt_d = stride_cnt_q + 1'b1;
         end
      end

      take = due & en;

      unique case (state_q)
         ST_FILL: begin
            if (take) begin
               state_d = ST_PEND;
            end else if (due) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (take) begin
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            // A new window in the handshake cycle keeps us
            // pending; without a handshake it replaces the old.
            if (fire_ready && !take) begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase

      if (take) begin
         fire_idx_d = next_idx_q;
         next_idx_d = next_idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FILL;
         fill_cnt_q   <= '0;
         stride_cnt_q <= '0;
         filled_q     <= 1'b0;
         fire_idx_q   <= '0;
         next_idx_q   <= '0;
      end else begin
         state_q      <= state_d;
         fill_cnt_q   <= fill_cnt_d;
         stride_cnt_q <= stride_cnt_d;
         filled_q     <= filled_d;
         fire_idx_q   <= fire_idx_d;
         next_idx_q   <= next_idx_d;
      end
   end

   assign fire_valid = (state_q == ST_PEND);
   assign fire_idx   = fire_idx_q;
   assign filled     = filled_q;

`ifdef WINDOW_SCHED_STATS_EN
   logic drop_ev;
   logic overflow_q;
   logic overflow_d;

   assign drop_ev = take && (state_q == ST_PEND) && !fire_ready;

   sat_counter #(
      .W (DROP_W)
   ) u_drop_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (drop_ev),
      .count (drop_cnt)
   );

   always_comb begin
      overflow_d = overflow_q | drop_ev;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`else
   assign drop_cnt = '0;
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_window_sched.sv
// Directed scoreboard bench for window_sched
// (WINDOW_SIZE=32, STRIDE=8).
module tb_window_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        in_valid = 1'b0;
   logic        fire_ready = 1'b0;
   logic        fire_valid;
   logic [15:0] fire_idx;
   logic        filled;
   logic [7:0]  drop_cnt;
   logic        overflow;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int nidx;

`ifdef WINDOW_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   window_sched #(
      .WINDOW_SIZE (32),
      .STRIDE      (8),
      .IDX_W       (16),
      .DROP_W      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_valid   (in_valid),
      .fire_ready (fire_ready),
      .fire_valid (fire_valid),
      .fire_idx   (fire_idx),
      .filled     (filled),
      .drop_cnt   (drop_cnt),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   function automatic int dexp(input int n);
      return STATS ? n : 0;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   // One clock: inputs set at the falling edge, outputs
   // sampled 1 time unit after the rising edge.
   task automatic step(input bit v, input bit r);
      @(negedge clk);
      in_valid   = v;
      fire_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) step(1'b0, 1'b0);
      chk("rst_fv", fire_valid, 0);
      chk("rst_idx", fire_idx, 0);
      chk("rst_filled", filled, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_ovf", overflow, 0);
      rst = 1'b0;

      // Fill: 31 samples then the 32nd
      repeat (31) step(1'b1, 1'b0);
      chk("fill31_filled", filled, 0);
      chk("fill31_fv", fire_valid, 0);
      step(1'b1, 1'b0);
      chk("fill32_filled", filled, 1);
      chk("fill32_fv", fire_valid, 1);
      chk("fill32_idx", fire_idx, 0);
      step(1'b0, 1'b1);
      chk("ack0_fv", fire_valid, 0);
      nidx = 1;

      // Stride pulses with ready held high
      for (int i = 1; i <= 64; i++) begin
         step(1'b1, 1'b1);
         if (i % 8 == 0) exp_q.push_back(nidx++);
         chk("pulse_fv", fire_valid, 32'(i % 8 == 0));
         if (fire_valid && exp_q.size() > 0)
            chk("pulse_idx", fire_idx, exp_q.pop_front());
      end
      chk("pulse_left", exp_q.size(), 0);
      chk("pulse_drop", drop_cnt, 0);
      step(1'b0, 1'b1);
      chk("pulse_ack", fire_valid, 0);

      // Consumer stalled: three replacements
      repeat (8) step(1'b1, 1'b0);
      chk("stall_fv0", fire_valid, 1);
      chk("stall_idx0", fire_idx, 9);
      repeat (24) step(1'b1, 1'b0);
      chk("stall_idx", fire_idx, 12);
      chk("stall_drop", drop_cnt, dexp(3));
      chk("stall_ovf", overflow, dexp(1));
      chk("stall_fv", fire_valid, 1);

      // Handshake in the same cycle as a due sample
      repeat (7) step(1'b1, 1'b0);
      chk("coin_pre_idx", fire_idx, 12);
      step(1'b1, 1'b1);
      chk("coin_fv", fire_valid, 1);
      chk("coin_idx", fire_idx, 13);
      chk("coin_drop", drop_cnt, dexp(3));
      step(1'b0, 1'b1);
      chk("coin_ack", fire_valid, 0);

      // Disabled for 16 samples; alignment kept
      en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0);
         chk("en0_fv", fire_valid, 0);
      end
      chk("en0_idx", fire_idx, 13);
      en = 1'b1;
      repeat (7) step(1'b1, 1'b0);
      chk("en1_fv7", fire_valid, 0);
      step(1'b1, 1'b0);
      chk("en1_fv8", fire_valid, 1);
      chk("en1_idx", fire_idx, 14);

      // Disabled while pending: window held, no drop
      en = 1'b0;
      repeat (8) step(1'b1, 1'b0);
      chk("hold_fv", fire_valid, 1);
      chk("hold_idx", fire_idx, 14);
      chk("hold_drop", drop_cnt, dexp(3));
      en = 1'b1;

      // Reach 5 drops, then reset while pending
      repeat (16) step(1'b1, 1'b0);
      chk("pre_rst_idx", fire_idx, 16);
      chk("pre_rst_drop", drop_cnt, dexp(5));
      rst = 1'b1;
      step(1'b1, 1'b1);
      chk("mid_rst_fv", fire_valid, 0);
      chk("mid_rst_idx", fire_idx, 0);
      chk("mid_rst_filled", filled, 0);
      chk("mid_rst_drop", drop_cnt, 0);
      chk("mid_rst_ovf", overflow, 0);
      rst = 1'b0;

      // Refill from scratch
      repeat (31) step(1'b1, 1'b0);
      chk("refill31_fv", fire_valid, 0);
      chk("refill31_filled", filled, 0);
      step(1'b1, 1'b0);
      chk("refill32_fv", fire_valid, 1);
      chk("refill32_idx", fire_idx, 0);
      chk("refill32_filled", filled, 1);
      chk("refill32_drop", drop_cnt, 0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/window_sched.md
WINDOW_SCHED -- requirements
Module: window_sched

Interface
REQ-001 Parameter WINDOW_SIZE, default 32, samples per window; SHALL be >= 2.
REQ-002 Parameter STRIDE, default 8, new samples between successive windows; SHALL be in 1..WINDOW_SIZE.
REQ-003 Parameter IDX_W, default 16, width of the window index counter.
REQ-004 Parameter DROP_W, default 8, width of the dropped-window counter.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  scheduling enable; when low, no window is declared due.
REQ-008 in_valid  in  1  a sample is written into the window buffer this cycle; the buffer cannot stall.
REQ-009 fire_ready  in  1  consumer accepts the pending window this cycle.
REQ-010 fire_valid  out  1  a window is pending for the consumer.
REQ-011 fire_idx  out  IDX_W  sequence number of the pending window.
REQ-012 filled  out  1  at least WINDOW_SIZE samples seen since reset.
REQ-013 drop_cnt  out  DROP_W  saturating count of overwritten windows.
REQ-014 overflow  out  1  sticky flag: at least one window dropped.

Function
REQ-015 The FSM SHALL have states FILL, WAIT, and PEND, encoded as an enum from the package.
REQ-016 In FILL, fill_cnt SHALL increment on each in_valid; when the WINDOW_SIZE-th sample arrives, filled SHALL go high on the next edge and first window becomes due.
REQ-017 After filled, stride_cnt SHALL count in_valid from 0 up to STRIDE-1; the sample that completes a stride SHALL make a window due and wrap stride_cnt to 0.
REQ-018 With STRIDE == WINDOW_SIZE windows SHALL be non-overlapping; with STRIDE == 1 every post-fill sample SHALL make a window due.
REQ-019 When a window becomes due in WAIT (or on FILL exit) with en high, the FSM SHALL enter PEND and fire_valid SHALL be high on the next cycle.
REQ-020 fire_valid SHALL stay high, with fire_idx stable, until the cycle in which fire_ready is high, then drop on the next edge unless a new window is due in that same cycle.
REQ-021 fire_idx SHALL start at 0 and increment by 1 for every due window, including dropped ones; it wraps modulo 2^IDX_W.
REQ-022 If a window becomes due while a window is in PEND and fire_ready is low, the old window SHALL be dropped. fire_idx SHALL advance. drop_cnt SHALL increment and saturate at all-ones. overflow SHALL set.
REQ-023 If a window becomes due in the same cycle a handshake completes, there SHALL be no drop. fire_valid SHALL stay high with the incremented fire_idx.
REQ-024 With en low, stride_cnt and fill_cnt SHALL still track samples, so window alignment is preserved. Due events SHALL be discarded without a drop count, fire_idx advance, or PEND entry. A window already in PEND SHALL remain pending.
REQ-025 Latency: the due sample's cycle to fire_valid high SHALL be exactly 1 cycle.

Reset
REQ-026 On rst high at an edge: state is FILL, fill_cnt and stride_cnt are 0, fire_valid is 0, fire_idx is 0, filled is 0, drop_cnt is 0, and overflow is 0. This SHALL also apply mid-PEND, and the pending window SHALL be discarded.
REQ-027 rst SHALL take priority over in_valid and fire_ready in the same cycle.

Configuration
REQ-028 Macro WINDOW_SCHED_STATS_EN: when defined, drop_cnt and overflow SHALL behave as in REQ-022. When undefined, both SHALL be driven constant 0 and their registers omitted. Drop/replace behaviour is unchanged.

Structure
REQ-029 Package window_pkg SHALL hold the sched_state_t enum and the default WINDOW_SIZE/STRIDE constants, shared with the window generator.
REQ-030 Sub-module sat_counter (parameterised width, inc, clr, saturating) SHALL implement drop_cnt. All other logic SHALL reside in window_sched.

Verification
REQ-031 Reset release, 31 samples -> filled=0, fire_valid=0; 32nd sample -> next cycle filled=1, fire_valid=1, fire_idx=0.
REQ-032 STRIDE=8, fire_ready held 1, 64 samples after fill -> 8 single-cycle fire_valid pulses, idx 1..8, each 1 cycle after every 8th sample, drop_cnt=0.
REQ-033 fire_ready held 0, 24 samples after first window -> fire_idx=3, drop_cnt=3, overflow=1, fire_valid still 1.
REQ-034 Handshake coincident with new due sample -> fire_valid stays 1, fire_idx increments, drop_cnt unchanged.
REQ-035 en low for 16 post-fill samples, then high -> no fire, fire_idx unchanged. The next due window lands on the original 8-sample alignment.
REQ-036 rst asserted while PEND with drop_cnt=5 -> next cycle all outputs 0. A refill of 32 samples is needed before the next fire_idx=0. With WINDOW_SCHED_STATS_EN undefined, drop_cnt and overflow are 0 throughout.
